// File: rtl/uart_status_pkg.sv
// Shared constants, FSM state types and message-table helpers for the UART status transmitter.
package uart_status_pkg;

  localparam logic [2:0] MSG_OK   = 3'd0;
  localparam logic [2:0] MSG_ERR  = 3'd1;
  localparam logic [2:0] MSG_TEMP = 3'd2;
  localparam logic [2:0] MSG_HUM  = 3'd3;
  localparam logic [2:0] MSG_UP   = 3'd4;
  localparam logic [2:0] MSG_DOWN = 3'd5;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_EQ = 8'h3D;

  localparam int MAX_MSG_LEN = 6;

  typedef enum logic [1:0] {T_IDLE, T_LOAD, T_SEND, T_DONE} seq_state_e;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_e;

  // Total characters including the trailing CR LF; reserved ids fall back to "ERR".
  function automatic logic [2:0] msg_len(input logic [2:0] id);
    case (id)
      MSG_OK, MSG_UP:             return 3'd4;
      MSG_TEMP, MSG_HUM, MSG_DOWN: return 3'd6;
      default:                    return 3'd5;
    endcase
  endfunction

  function automatic logic [7:0] msg_char(input logic [2:0] id, input logic [7:0] val,
                                          input logic [2:0] idx);
    logic [7:0]      sat;
    logic [7:0]      tens, ones;
    logic [7:0][7:0] s;
    sat  = (val > 8'd99) ? 8'd99 : val;
    tens = ASCII_0 + sat / 8'd10;
    ones = ASCII_0 + sat % 8'd10;
    s    = '0;
    case (id)
      MSG_OK:   s[3:0] = {ASCII_LF, ASCII_CR, 8'h4B, 8'h4F};
      MSG_TEMP: s[5:0] = {ASCII_LF, ASCII_CR, ones, tens, ASCII_EQ, 8'h54};
      MSG_HUM:  s[5:0] = {ASCII_LF, ASCII_CR, ones, tens, ASCII_EQ, 8'h48};
      MSG_UP:   s[3:0] = {ASCII_LF, ASCII_CR, 8'h50, 8'h55};
      MSG_DOWN: s[5:0] = {ASCII_LF, ASCII_CR, 8'h4E, 8'h57, 8'h4F, 8'h44};
      default:  s[4:0] = {ASCII_LF, ASCII_CR, 8'h52, 8'h52, 8'h45};
    endcase
    return s[idx];
  endfunction

endpackage

// File: rtl/uart_status_transmitter_if.sv
// Request handshake between a status producer and the UART status transmitter.
interface uart_status_transmitter_if;
  logic       msg_valid;
  logic [2:0] msg_id;
  logic [7:0] msg_val;
  logic       msg_ready;

  modport master (output msg_valid, msg_id, msg_val, input msg_ready);
  modport slave  (input msg_valid, msg_id, msg_val, output msg_ready);
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with per-bit baud counter; a start during the last stop cycle chains frames gap-free.
module uart_tx_byte import uart_status_pkg::*; #(
  parameter int BIT_TIME = 10416
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       done,
  output logic       tx
);

  localparam int CW = (BIT_TIME > 1) ? $clog2(BIT_TIME) : 1;

  ser_state_e    state, nxt;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    sh, sh_d;
  logic          tx_d, bit_end;

  assign bit_end = (cnt == CW'(BIT_TIME - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= nxt;
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      sh      <= sh_d;
      tx      <= tx_d;
    end
  end

  always_comb begin
    nxt       = state;
    cnt_d     = cnt + CW'(1);
    bit_idx_d = bit_idx;
    sh_d      = sh;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          nxt  = S_START;
          sh_d = data;
        end
      end
      S_START: if (bit_end) begin
        cnt_d     = '0;
        bit_idx_d = '0;
        nxt       = S_DATA;
      end
      S_DATA: if (bit_end) begin
        cnt_d = '0;
        if (bit_idx == 3'd7) nxt = S_STOP;
        else begin
          bit_idx_d = bit_idx + 3'd1;
          sh_d      = sh >> 1;
        end
      end
      S_STOP: if (bit_end) begin
        done  = 1'b1;
        cnt_d = '0;
        if (start) begin
          nxt  = S_START;
          sh_d = data;
        end else nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
    // Line level is registered from the next state so tx never glitches.
    case (nxt)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = sh_d[0];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: rtl/uart_status_transmitter.sv
// Sequences fixed ASCII status messages (with saturated two-digit values) onto a UART line.
module uart_status_transmitter import uart_status_pkg::*; #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic                      clk,
  input  logic                      rst,
  uart_status_transmitter_if.slave  msg_if,
  output logic                      tx,
  output logic                      busy
);

  localparam int BIT_TIME = CLK_FREQ / BAUD;

  seq_state_e state, nxt;
  logic [2:0] id_q, idx_q, idx_d, idx_nx;
  logic [7:0] val_q, byte_q, byte_d, ser_data;
  logic       ser_start, ser_done, ready, accept;

  assign ready            = (state == T_IDLE);
  assign msg_if.msg_ready = ready;
  assign busy             = ~ready;
  assign idx_nx           = idx_q + 3'd1;

  // The last stop cycle also takes a waiting request so consecutive messages leave no idle bit.
  assign accept = msg_if.msg_valid && (ready || (state == T_DONE && ser_done));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= T_IDLE;
      idx_q  <= '0;
      id_q   <= '0;
      val_q  <= '0;
      byte_q <= '0;
    end else begin
      state  <= nxt;
      idx_q  <= idx_d;
      byte_q <= byte_d;
      if (accept) begin
        id_q  <= msg_if.msg_id;
        val_q <= msg_if.msg_val;
      end
    end
  end

  always_comb begin
    nxt       = state;
    idx_d     = idx_q;
    byte_d    = byte_q;
    ser_start = 1'b0;
    ser_data  = byte_q;
    case (state)
      T_IDLE: idx_d = '0;
      // Next character is fetched while the current one is still on the line.
      T_LOAD: begin
        byte_d = msg_char(id_q, val_q, idx_q);
        nxt    = T_SEND;
      end
      T_SEND: if (ser_done) begin
        ser_start = 1'b1;
        idx_d     = idx_nx;
        nxt       = (idx_nx == msg_len(id_q)) ? T_DONE : T_LOAD;
      end
      T_DONE: if (ser_done) begin
        idx_d = '0;
        nxt   = T_IDLE;
      end
      default: nxt = T_IDLE;
    endcase
    if (accept) begin
      ser_start = 1'b1;
      ser_data  = msg_char(msg_if.msg_id, msg_if.msg_val, 3'd0);
      idx_d     = 3'd1;
      nxt       = T_LOAD;
    end
  end

  uart_tx_byte #(.BIT_TIME(BIT_TIME)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .start (ser_start),
    .data  (ser_data),
    .done  (ser_done),
    .tx    (tx)
  );

endmodule

// File: doc/uart_status_transmitter.md
UART_STATUS_TRANSMITTER -- requirements
Module: uart_status_transmitter

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line rate in bit/s; BIT_TIME = CLK_FREQ/BAUD (integer division, 10416 at defaults).
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 rst  input  1  synchronous active-low reset.
REQ-006 msg_valid  input  1  message request present.
REQ-007 msg_id  input  3  message selector (see REQ-012).
REQ-008 msg_val  input  8  unsigned value for numeric messages.
REQ-009 msg_ready  output  1  block idle, can accept a request.
REQ-010 tx  output  1  UART serial line, idle high.
REQ-011 busy  output  1  high while a message is being serialized; equals ~msg_ready.

Function
REQ-012 Message table, each followed by 0x0D 0x0A: 0 "OK"; 1 "ERR"; 2 "T=dd"; 3 "H=dd"; 4 "UP"; 5 "DOWN"; 6 and 7 reserved, sent as "ERR".
REQ-013 dd = two ASCII decimal digits of msg_val, tens first, leading zero kept (7 -> "07"); msg_val > 99 saturates to "99".
REQ-014 Request accepted on the rising edge where msg_valid && msg_ready; msg_id/msg_val latched on that edge; later input changes are ignored.
REQ-015 msg_ready deasserts the cycle after acceptance and stays low until the message completes.
REQ-016 Start bit of the first character begins the cycle after acceptance.
REQ-017 Frame: 8N1, start 0, data LSB first, stop 1; each bit held exactly BIT_TIME cycles.
REQ-018 Characters go back-to-back with no idle gap; message length N chars = N*10*BIT_TIME cycles.
REQ-019 msg_ready reasserts the cycle after the last stop bit ends; a msg_valid held high is accepted on that same edge (zero idle gap between messages).
REQ-020 Top FSM states: IDLE, LOAD (select next char, one cycle max inside the bit period budget, no line gap), SEND (byte serializer active), DONE -> IDLE; the character index wraps to 0 on return to IDLE.
REQ-021 Serializer FSM states: IDLE, START, DATA (bit index 0..7), STOP; baud counter counts 0..BIT_TIME-1 and restarts on every bit.
REQ-022 msg_valid while busy is ignored, no queuing.

Reset
REQ-023 On rst low at a clock edge: tx=1, msg_ready=1 (from the first edge with rst high), busy=0, all FSMs to IDLE, counters 0.
REQ-024 Reset mid-message aborts it immediately; tx returns high the cycle after reset is sampled; the aborted message is not resumed.
REQ-025 A msg_valid present in the same cycle as active reset is not accepted.

Structure
REQ-026 Shared package uart_status_pkg holds: message ID constants, ASCII constants (CR 0x0D, LF 0x0A, '0' 0x30, '=' 0x3D), max message length 6, FSM state enums.
REQ-027 One sub-module, uart_tx_byte (baud counter + 8N1 serializer, start/done handshake, BIT_TIME parameter); message sequencing and decimal conversion remain in the top.

Verification
REQ-028 id=0 -> line bytes 4F 4B 0D 0A, msg_ready low for exactly 40*BIT_TIME cycles.
REQ-029 id=2, val=25 -> 54 3D 32 35 0D 0A; id=3, val=7 -> 48 3D 30 37 0D 0A; id=3, val=150 -> 48 3D 39 39 0D 0A.
REQ-030 id=5 then id=4 with msg_valid held high -> "DOWN\r\n" then "UP\r\n", second start bit immediately after first's last stop bit, no idle cycle.
REQ-031 id=6 and id=7 -> 45 52 52 0D 0A each.
REQ-032 Change msg_id/msg_val during transmission, pulse msg_valid while busy -> output unaffected, no extra message.
REQ-033 Assert rst mid data bit of character 2 -> tx=1 next cycle, msg_ready=1 after release, fresh id=0 request transmits cleanly.
